// File: rtl/tt_um_taghreed_eialsalman_mux_in_cond.sv
// Input conditioning for the downstream 2:1 mux: synchronises and debounces raw A, B and
// the S button, and derives a select level (toggle or direct) plus change/busy flags.
module tt_um_taghreed_eialsalman_mux_in_cond #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int NCH   = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [NCH-1:0] w_clean;
  logic [NCH-1:0] w_busy;

  logic w_mode;
  logic w_s_rise;
  logic w_mode_fall;
  logic w_sel_next;
  logic r_mode_prev;
  logic r_s_prev;
  logic r_sel;
  logic r_sel_chg;

  // ena, uio_in and the upper ui_in bits carry no function in this stage
  logic w_unused;
  assign w_unused = &{1'b0, ena, uio_in, ui_in[7:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ui_in[3:0];
      r_sync2 <= r_sync1;
    end
  end

  // One debounce counter per channel: 0 = A, 1 = B, 2 = S
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_deb
      logic [CNT_W-1:0] r_cnt;
      logic             r_clean;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_clean <= 1'b0;
        end else if (r_sync2[gi] == r_clean) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_clean <= r_sync2[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_clean[gi] = r_clean;
      assign w_busy[gi]  = (r_cnt != '0);
    end
  endgenerate

  assign w_mode      = r_sync2[3];
  assign w_s_rise    = w_clean[2] & ~r_s_prev;
  assign w_mode_fall = r_mode_prev & ~w_mode;

  // A press landing on the same cycle MODE drops to toggle is still handled as direct
  always_comb begin
    w_sel_next = r_sel;
    if (w_mode || (w_mode_fall && w_s_rise)) begin
      w_sel_next = w_clean[2];
    end else if (w_s_rise) begin
      w_sel_next = ~r_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_prev <= 1'b0;
      r_s_prev    <= 1'b0;
      r_sel       <= 1'b0;
      r_sel_chg   <= 1'b0;
    end else begin
      r_mode_prev <= w_mode;
      r_s_prev    <= w_clean[2];
      r_sel       <= w_sel_next;
      r_sel_chg   <= (w_sel_next != r_sel);
    end
  end

  assign uo_out  = {3'b000, |w_busy, r_sel_chg, r_sel, w_clean[1], w_clean[0]};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
